// File: rtl/ka64_seq_ctrl.sv
// ka64_seq_ctrl: 64x64 carry-less multiplier built from one 32-bit Karatsuba
// multiplier used on three consecutive cycles (low halves, high halves,
// XOR-folded halves). The three partial products are then recombined into a
// 127-bit result. Operands arrive and the result leaves on valid/ready
// handshakes.

// KA_32bit: combinational 32x32 carry-less product built from three 16x16
// schoolbook products (one Karatsuba level).
module KA_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [62:0] p
);

    function automatic logic [30:0] clmul16(input logic [15:0] x, input logic [15:0] z);
        logic [30:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (z[i]) begin
                acc = acc ^ ({15'b0, x} << i);
            end
        end
        return acc;
    endfunction

    logic [30:0] z0;
    logic [30:0] z2;
    logic [30:0] zm;
    logic [62:0] mid;

    // Karatsuba recombine of the three half-width products
    always_comb begin
        z0  = clmul16(a[15:0], b[15:0]);
        z2  = clmul16(a[31:16], b[31:16]);
        zm  = clmul16(a[15:0] ^ a[31:16], b[15:0] ^ b[31:16]);
        mid = {32'b0, z0 ^ z2 ^ zm};
        p   = {32'b0, z0} ^ (mid << 16) ^ ({32'b0, z2} << 32);
    end

endmodule

module ka64_seq_ctrl (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   a,
    input  logic [63:0]   b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [126:0]  y,
    output logic          busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] MUL_LO  = 3'd1;
    localparam logic [2:0] MUL_HI  = 3'd2;
    localparam logic [2:0] MUL_MID = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]  state;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [62:0] p0;
    logic [62:0] p2;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [62:0] pm;

    KA_32bit u_ka (
        .a (mul_a),
        .b (mul_b),
        .p (pm)
    );

    // Select the multiplier operands for the current phase
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            MUL_LO: begin
                mul_a = ra[31:0];
                mul_b = rb[31:0];
            end
            MUL_HI: begin
                mul_a = ra[63:32];
                mul_b = rb[63:32];
            end
            MUL_MID: begin
                mul_a = ra[31:0] ^ ra[63:32];
                mul_b = rb[31:0] ^ rb[63:32];
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    // Sequencer, operand capture, partial products and final recombine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            p0    <= '0;
            p2    <= '0;
            y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra    <= a;
                        rb    <= b;
                        state <= MUL_LO;
                    end
                end
                MUL_LO: begin
                    p0    <= pm;
                    state <= MUL_HI;
                end
                MUL_HI: begin
                    p2    <= pm;
                    state <= MUL_MID;
                end
                MUL_MID: begin
                    y     <= {64'b0, p0}
                           ^ ({64'b0, p0 ^ p2 ^ pm} << 32)
                           ^ ({64'b0, p2} << 64);
                    state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake and status outputs decode the registered state only
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_ka64_seq_ctrl.sv
// Bench for ka64_seq_ctrl: a transaction-level reference (latency counter plus
// a queue of expected products from a bit-serial carry-less multiply) is
// compared against the DUT every cycle. Directed cases pin literal results.
module tb_ka64_seq_ctrl;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [63:0]   a = '0;
    logic [63:0]   b = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [126:0]  y;

    int total = 0;
    int bad = 0;
    int n_acc = 0;
    int n_done = 0;

    logic [126:0] expq[$];
    bit           m_busy = 1'b0;
    int           m_wait = 0;
    bit           exp_ov;

    always #5 clk = ~clk;

    ka64_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [126:0] got, input logic [126:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic [126:0] clmul64(input logic [63:0] x, input logic [63:0] z);
        logic [126:0] acc;
        acc = '0;
        for (int i = 0; i < 64; i++) begin
            if (z[i]) acc = acc ^ ({63'b0, x} << i);
        end
        return acc;
    endfunction

    // Reference: an accepted pair makes out_valid rise three edges later and
    // holds it until the consumer takes it; the expected product is queued.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_in_ready", {126'b0, in_ready}, 127'd1);
            check("rst_out_valid", {126'b0, out_valid}, 127'd0);
            check("rst_busy", {126'b0, busy}, 127'd0);
            check("rst_y", y, 127'd0);
            expq.delete();
            m_busy = 1'b0;
            m_wait = 0;
            n_acc  = n_done;
        end else begin
            exp_ov = m_busy && (m_wait == 0);
            check("in_ready", {126'b0, in_ready}, {126'b0, !m_busy});
            check("out_valid", {126'b0, out_valid}, {126'b0, exp_ov});
            check("busy", {126'b0, busy}, {126'b0, m_busy});
            if (exp_ov) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL y_no_expected got=%h exp=none", y);
                end else begin
                    check("y", y, expq[0]);
                end
            end
            if (!m_busy && in_valid) begin
                expq.push_back(clmul64(a, b));
                m_busy = 1'b1;
                m_wait = 3;
                n_acc++;
            end else if (m_busy && m_wait > 0) begin
                m_wait--;
            end else if (exp_ov && out_ready) begin
                void'(expq.pop_front());
                m_busy = 1'b0;
                n_done++;
            end
        end
    end

    // Issue one pair, wait for it, check latency and the literal result
    task automatic run_one(input logic [63:0] aa, input logic [63:0] bb,
                           input logic [126:0] ey, input string nm, input bit rdy);
        int lat;
        bit seen;
        @(posedge clk); #1;
        a = aa; b = bb; in_valid = 1'b1; out_ready = rdy;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s_accept_timeout got=in_ready_low exp=in_ready_high", nm);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        lat = 0;
        seen = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (out_valid) begin lat = i; seen = 1'b1; break; end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s_result_timeout got=no_out_valid exp=out_valid", nm);
        end else begin
            check({nm, "_latency"}, lat, 127'd4);
            check({nm, "_y"}, y, ey);
            if (rdy) begin
                @(negedge clk);
                check({nm, "_pulse"}, {126'b0, out_valid}, 127'd0);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic [63:0] ra2;
        logic [63:0] rb2;
        bit hs;
        bit seen;
        int sent;
        int cyc;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_one(64'h3, 64'h3, 127'h5, "basic", 1'b1);
        run_one(64'hFFFF_FFFF_FFFF_FFFF, 64'h3, (127'd1 << 64) | 127'd1, "fold", 1'b1);
        run_one(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 127'd1 << 126, "top", 1'b1);
        r = {$urandom, $urandom};
        run_one(64'h0, r, 127'd0, "zero", 1'b1);
        ra2 = {$urandom, $urandom};
        rb2 = {$urandom, $urandom};
        run_one(ra2, rb2, clmul64(ra2, rb2), "rand_dir", 1'b1);

        // Backpressure with a second pair waiting at the input
        run_one(64'h5, 64'h7, 127'h1B, "bp_first", 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = 64'hF0; b = 64'h11; out_ready = 1'b0;
            @(negedge clk);
            check("bp_in_ready", {126'b0, in_ready}, 127'd0);
            check("bp_out_valid", {126'b0, out_valid}, 127'd1);
            check("bp_y_hold", y, 127'h1B);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin seen = 1'b1; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 20 && seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                check("bp_second_y", y, 127'hFF0);
                break;
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL bp_second_accept got=in_ready_low exp=in_ready_high");
        end

        // Reset during MUL_HI discards the operation
        @(posedge clk); #1;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("rst_test_idle", {126'b0, in_ready}, 127'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", {126'b0, out_valid}, 127'd0);
        check("async_in_ready", {126'b0, in_ready}, 127'd1);
        check("async_y", y, 127'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_no_result", {126'b0, out_valid}, 127'd0);
        end

        // Random back-to-back traffic with consumer gaps
        sent = 0;
        cyc = 0;
        @(posedge clk); #1;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        in_valid = 1'b1;
        while (sent < 1000 && cyc < 40000) begin
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) begin
                sent++;
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                in_valid = ($urandom_range(0, 3) != 0) && (sent < 1000);
            end else if (!in_valid && sent < 1000) begin
                in_valid = 1'(($urandom_range(0, 1)));
            end
            out_ready = ($urandom_range(0, 2) != 0);
        end
        if (sent < 1000) begin
            total++; bad++;
            $display("FAIL random_issue got=%0d exp=1000", sent);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (expq.size() == 0 && in_ready) break;
        end
        check("drain_empty", expq.size(), 127'd0);
        check("acc_vs_done", n_done, n_acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
